// File: rtl/simple_processor_pkg.sv
// Shared constants, instruction field layout and func codes for the simple processor.
package simple_processor_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_REGS    = 32;
  localparam int REG_AW      = $clog2(NUM_REGS);
  localparam int INSTR_WIDTH = 20;

  // Instruction field positions; imm overlaps rs2 and bit 5.
  localparam int FUNC_LSB = 16;
  localparam int FUNC_W   = 4;
  localparam int RD_LSB   = 11;
  localparam int RS1_LSB  = 6;
  localparam int RS2_LSB  = 0;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 6;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD     = 4'h0,
    FUNC_SUB     = 4'h1,
    FUNC_ADDI    = 4'h2,
    FUNC_INVALID = 4'hF
  } func_t;

  // Only ADD, SUB and ADDI are executable; every other code is flagged illegal.
  function automatic logic func_is_legal(input logic [FUNC_W-1:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_ADDI);
  endfunction

endpackage

// File: rtl/sp_regfile.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero.
module sp_regfile
  import simple_processor_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int NR = NUM_REGS,
  parameter int AW = REG_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] regs_q [NR];
  logic [AW-1:0] raddr  [2];
  logic [DW-1:0] rdata  [2];

  // Storage update: reset clears every entry, writes to x0 are discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;

  // Each read port sees a same-cycle write (bypass); x0 always reads zero.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rd
    assign rdata[gi] = (raddr[gi] == '0)                  ? '0      :
                       (we_i && (waddr_i == raddr[gi]))   ? wdata_i :
                                                            regs_q[raddr[gi]];
  end

  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

endmodule

// File: rtl/sp_operand_fetch.sv
// Issue/operand-fetch stage: decodes, reads operands, tracks pending writes and
// holds a single-entry output register towards the ALU.
module sp_operand_fetch
  import simple_processor_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   wb_en_i,
  input  logic [REG_AW-1:0]      wb_addr_i,
  input  logic [DATA_WIDTH-1:0]  wb_data_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [DATA_WIDTH-1:0]  ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0]  ex_rs2_data_o,
  output logic [FUNC_W-1:0]      ex_func_o,
  output logic [IMM_W-1:0]       ex_imm_o,
  output logic [REG_AW-1:0]      ex_rd_o,
  output logic                   ex_illegal_o
);

  // Instruction field decode
  logic [FUNC_W-1:0] func;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0]  imm;
  logic              legal, is_addi;

  assign func    = instr_i[FUNC_LSB +: FUNC_W];
  assign rd      = instr_i[RD_LSB   +: REG_AW];
  assign rs1     = instr_i[RS1_LSB  +: REG_AW];
  assign rs2     = instr_i[RS2_LSB  +: REG_AW];
  assign imm     = instr_i[IMM_LSB  +: IMM_W];
  assign legal   = func_is_legal(func);
  assign is_addi = (func == FUNC_ADDI);

  logic [DATA_WIDTH-1:0] rs1_rdata, rs2_rdata;

  sp_regfile u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wb_en_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1),
    .rdata1_o (rs1_rdata),
    .raddr2_i (rs2),
    .rdata2_o (rs2_rdata)
  );

  // Scoreboard and hazard detection
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [NUM_REGS-1:0] wb_hit, pending;
  logic                hazard, slot_free, accept;

  // One-hot of the register being written back this cycle.
  always_comb begin
    wb_hit = '0;
    if (wb_en_i) begin
      wb_hit[wb_addr_i] = 1'b1;
    end
  end

  // A writeback landing this cycle resolves the dependency immediately.
  assign pending = sb_q & ~wb_hit;

  assign hazard = legal & (pending[rs1]
                         | (!is_addi & pending[rs2])
                         | ((rd != '0) & pending[rd]));

  assign slot_free     = !ex_valid_o | ex_ready_i;
  assign instr_ready_o = slot_free & !hazard & !rst_i;
  assign accept        = instr_valid_i & instr_ready_o;

  // Scoreboard next state: writeback clears, issue sets; set wins on a collision.
  always_comb begin
    sb_d = sb_q & ~wb_hit;
    if (accept && legal && (rd != '0)) begin
      sb_d[rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Output pipeline register
  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [FUNC_W-1:0]     ex_func_q, ex_func_d;
  logic [IMM_W-1:0]      ex_imm_q, ex_imm_d;
  logic [REG_AW-1:0]     ex_rd_q, ex_rd_d;
  logic                  ex_illegal_q, ex_illegal_d;

  // Load a new payload on accept, otherwise hold it and retire valid once consumed.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_func_d    = ex_func_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_illegal_d = ex_illegal_q;
    if (accept) begin
      ex_valid_d   = 1'b1;
      ex_rs1_d     = legal ? rs1_rdata : '0;
      ex_rs2_d     = (legal && !is_addi) ? rs2_rdata : '0;
      ex_func_d    = func;
      ex_imm_d     = imm;
      ex_rd_d      = rd;
      ex_illegal_d = !legal;
    end else if (ex_ready_i) begin
      ex_valid_d   = 1'b0;
    end
  end

  // Output register state; reset drops any in-flight payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q   <= 1'b0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_func_q    <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_func_q    <= ex_func_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_rs1_data_o = ex_rs1_q;
  assign ex_rs2_data_o = ex_rs2_q;
  assign ex_func_o     = ex_func_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_illegal_o  = ex_illegal_q;

endmodule

// File: tb/tb_sp_operand_fetch.sv
// Self-checking bench for sp_operand_fetch: directed stimulus, queue-based scoreboard.
module tb_sp_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [19:0] instr_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [3:0]  ex_func_o;
  logic [5:0]  ex_imm_o;
  logic [4:0]  ex_rd_o;
  logic        ex_illegal_o;

  sp_operand_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_func_o     (ex_func_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rd_o       (ex_rd_o),
    .ex_illegal_o  (ex_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  func;
    logic [5:0]  imm;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mregs [32];
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk_r(input logic [3:0] f, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f, rd, rs1, 1'b0, rs2};
  endfunction

  function automatic logic [19:0] mk_i(input logic [3:0] f, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [5:0] imm);
    return {f, rd, rs1, imm};
  endfunction

  // Reference read of the bench's own register model, including same-cycle bypass.
  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_en_i && wb_addr_i == r) return wb_data_i;
    return mregs[r];
  endfunction

  // Scoreboard monitor: compare outputs being consumed, then record newly accepted work.
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    logic lg;
    if (rst_i) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else begin
      if (ex_valid_o && ex_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(ex_valid_o), 32'h0);
        end else begin
          e = exp_q.pop_front();
          $display("txn func=%h rd=%0d rs1=%h rs2=%h imm=%h ill=%0d",
                   ex_func_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_illegal_o);
          chk("rs1_data", ex_rs1_data_o, e.rs1);
          chk("rs2_data", ex_rs2_data_o, e.rs2);
          chk("func", 32'(ex_func_o), 32'(e.func));
          chk("imm", 32'(ex_imm_o), 32'(e.imm));
          chk("illegal", 32'(ex_illegal_o), 32'(e.ill));
          if (!e.ill) chk("rd", 32'(ex_rd_o), 32'(e.rd));
        end
      end
      if (instr_valid_i && instr_ready_o) begin
        n.func = instr_i[19:16];
        n.rd   = instr_i[15:11];
        n.imm  = instr_i[5:0];
        lg     = (n.func == 4'h0) || (n.func == 4'h1) || (n.func == 4'h2);
        n.ill  = !lg;
        n.rs1  = lg ? mread(instr_i[10:6]) : 32'h0;
        n.rs2  = (lg && n.func != 4'h2) ? mread(instr_i[4:0]) : 32'h0;
        exp_q.push_back(n);
      end
      if (wb_en_i && wb_addr_i != 5'd0) mregs[wb_addr_i] = wb_data_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en_i   = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  task automatic offer(input logic [19:0] ins);
    instr_valid_i = 1'b1;
    instr_i       = ins;
  endtask

  task automatic idle();
    instr_valid_i = 1'b0;
    wb_en_i       = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;
    tick(); tick();
    chk("rst_ready", 32'(instr_ready_o), 32'h0);
    chk("rst_valid", 32'(ex_valid_o), 32'h0);
    chk("rst_rs1", ex_rs1_data_o, 32'h0);
    chk("rst_rd", 32'(ex_rd_o), 32'h0);
    rst_i = 1'b0;

    // Basic read of a written register
    wb(5'd5, 32'h0000_1234); tick(); idle();
    offer(mk_r(4'h0, 5'd3, 5'd5, 5'd0)); #1;
    chk("t1_ready", 32'(instr_ready_o), 32'h1);
    tick(); idle();
    chk("t1_valid", 32'(ex_valid_o), 32'h1);
    chk("t1_rs1_direct", ex_rs1_data_o, 32'h0000_1234);

    // Bypass of a same-cycle writeback into both operands
    wb(5'd7, 32'hDEAD_BEEF); offer(mk_r(4'h1, 5'd8, 5'd7, 5'd7)); #1;
    chk("t2_ready", 32'(instr_ready_o), 32'h1);
    tick(); idle();
    chk("t2_rs2_direct", ex_rs2_data_o, 32'hDEAD_BEEF);
    wb(5'd1, 32'h0000_0100); tick(); idle();

    // RAW stall released by writeback
    offer(mk_i(4'h2, 5'd4, 5'd1, 6'h3F)); tick();
    offer(mk_r(4'h0, 5'd6, 5'd4, 5'd4)); #1;
    chk("t3_stall0", 32'(instr_ready_o), 32'h0);
    tick();
    chk("t3_stall1", 32'(instr_ready_o), 32'h0);
    wb(5'd4, 32'd9); #1;
    chk("t3_release", 32'(instr_ready_o), 32'h1);
    tick(); idle();
    instr_i = mk_r(4'h0, 5'd9, 5'd4, 5'd0); #1;
    chk("t3_sb4_clear", 32'(instr_ready_o), 32'h1);
    instr_i = mk_r(4'h0, 5'd9, 5'd6, 5'd0); #1;
    chk("t3_sb6_set", 32'(instr_ready_o), 32'h0);
    tick();

    // Backpressure: payload held, input blocked
    ex_ready_i = 1'b0;
    offer(mk_r(4'h0, 5'd10, 5'd5, 5'd5)); tick();
    offer(mk_r(4'h1, 5'd11, 5'd5, 5'd0));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_blocked", 32'(instr_ready_o), 32'h0);
      chk("t4_hold_valid", 32'(ex_valid_o), 32'h1);
      chk("t4_hold_rs1", ex_rs1_data_o, 32'h0000_1234);
      chk("t4_hold_rd", 32'(ex_rd_o), 32'd10);
      tick();
    end
    ex_ready_i = 1'b1; #1;
    chk("t4_unblocked", 32'(instr_ready_o), 32'h1);
    tick(); idle();
    tick();
    chk("t4_drained", 32'(ex_valid_o), 32'h0);

    // x0 write ignored and never a hazard
    wb(5'd0, 32'hFFFF_FFFF); offer(mk_r(4'h0, 5'd0, 5'd0, 5'd0)); tick(); idle();
    offer(mk_r(4'h0, 5'd12, 5'd0, 5'd0)); #1;
    chk("t5_no_stall", 32'(instr_ready_o), 32'h1);
    tick(); idle(); tick();

    // Illegal instructions: flagged, no scoreboard set, never stalled
    offer(mk_r(4'hF, 5'd13, 5'd4, 5'd4)); tick();
    offer(mk_r(4'h0, 5'd14, 5'd13, 5'd13)); #1;
    chk("t6_no_sb_illegal", 32'(instr_ready_o), 32'h1);
    tick();
    offer(mk_r(4'h5, 5'd3, 5'd8, 5'd6)); #1;
    chk("t6_illegal_nostall", 32'(instr_ready_o), 32'h1);
    tick(); idle(); tick();

    // Reset during a RAW stall
    offer(mk_i(4'h2, 5'd15, 5'd1, 6'h01)); tick();
    offer(mk_r(4'h0, 5'd16, 5'd15, 5'd0)); #1;
    chk("t6_stall", 32'(instr_ready_o), 32'h0);
    tick();
    rst_i = 1'b1; #1;
    chk("t6_rst_ready", 32'(instr_ready_o), 32'h0);
    tick();
    chk("t6_rst_valid", 32'(ex_valid_o), 32'h0);
    rst_i = 1'b0; #1;
    chk("t6_sb_clear", 32'(instr_ready_o), 32'h1);
    tick(); idle();
    chk("t6_after_rst_valid", 32'(ex_valid_o), 32'h1);
    tick(); tick();
    chk("final_idle", 32'(ex_valid_o), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
